usr_seq: RTL and testbench
==========================

# usr_seq

Upstream command sequencer for the universal shift register (`univ_shift_reg`). It accepts a parallel word, a shift direction and a shift count over a valid/ready handshake. It then drives the register's `ctrl`/`d` inputs with one load, the requested number of shifts, and a hold. Its outputs connect directly to the register's `ctrl` and `d` ports, which replaces hand-written opcode stimulus with a repeatable, handshaked command stream.

## Interface
- `N`, default 4: data width; must match the downstream register's `N`.
- `CW`, default `$clog2(N+1)`: width of the shift-count field (derived; do not override).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset: `reset==0` at a rising edge forces the reset state.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  sequencer can accept a command.
- `in_data`  in  N  word to load.
- `in_dir`  in  1  0 = shift left (opcode 01), 1 = shift right (opcode 10).
- `in_shamt`  in  CW  number of shift cycles requested; values above N saturate to N.
- `ctrl`  out  2  opcode to the register: 00 hold, 01 shift left, 10 shift right, 11 load.
- `d`  out  N  parallel load data to the register.
- `busy`  out  1  high while a command is in progress (LOAD, SHIFT or DONE).
- `done`  out  1  one-cycle pulse marking command completion.

## Operation
- The FSM has four states: IDLE, LOAD, SHIFT, DONE.
- All outputs are registered, except `in_ready`, which is decoded as `state==IDLE`.
- IDLE
  - `in_ready=1`, `ctrl=00`.
  - Accept occurs on a rising edge with `in_valid & in_ready & reset`.
  - On accept, capture `in_data`→`d`, `in_dir`, and `min(in_shamt,N)`→`cnt`, then go to LOAD.
- LOAD: `ctrl=11`, `d`=captured word. Next state is SHIFT if `cnt!=0`, else DONE.
- SHIFT
  - `ctrl` = 01 if dir==0, 10 if dir==1.
  - `cnt` decrements each cycle.
  - Leave for DONE in the cycle where `cnt==1`, so exactly `cnt` shift cycles are issued.
- DONE: `ctrl=00`, `done=1` for exactly one cycle, then IDLE.
- `d` holds the captured word from accept until the next accept; it does not change during SHIFT or DONE.
- `in_valid` is ignored outside IDLE. Commands are never queued or dropped silently: the upstream must hold `in_valid` until it sees `in_ready`.
- Reset priority
  - A low `reset` at any edge, including mid-SHIFT, forces IDLE regardless of `in_valid`.
  - Reset values: `ctrl=00`, `d=0`, `cnt=0`, `busy=0`, `done=0`, `in_ready=1`.
  - No `done` pulse is produced for an aborted command.

## Timing
- Accept edge k → LOAD visible in cycle k+1 → shifts in cycles k+2 … k+1+S (S = saturated count) → DONE in cycle k+2+S → `in_ready` high again in cycle k+3+S.
- Command period is S+3 cycles; S=0 gives LOAD then DONE (3 cycles).
- `busy` is high in cycles k+1 … k+2+S and low in IDLE.
- The downstream register samples `ctrl`/`d` at the edge ending each cycle. After the LOAD cycle's closing edge it holds `in_data`; each SHIFT cycle's closing edge performs one shift.
- A new `in_valid` may be asserted during DONE, but it is accepted only at the first IDLE edge, never in DONE.

## Test plan
- Reset then left shift
  - Stimulus: hold `reset=0` 2 cycles, release; send `in_data=4'b1010`, `dir=0`, `shamt=4`.
  - Required: `ctrl` = 11,01,01,01,01,00 across cycles k+1…k+6, `done` high only in k+6, `d=1010` throughout.
  - Required: a connected `univ_shift_reg` shows `q=1010` after the LOAD edge.
- Right shift, partial count: `in_data=4'b0110`, `dir=1`, `shamt=2` → `ctrl` = 11,10,10,00; `busy` high 4 cycles; `in_ready` returns in cycle k+5.
- Zero and saturated counts
  - `shamt=0` → `ctrl` = 11,00, `done` in k+2.
  - With CW wide enough to express it (e.g. N=5, `shamt=7`) → exactly 5 shift cycles.
- Back-to-back commands: `in_valid` held high with two queued commands (1010/left/1, then 0101/right/1).
  - Second accept occurs at the first IDLE edge, with no lost or duplicated opcodes.
  - `ctrl` = 11,01,00,(00 idle edge),11,10,00.
- Reset mid-operation: assert `reset=0` during the second SHIFT cycle of a `shamt=4` command → next cycle `ctrl=00`, `busy=0`, `in_ready=1`, `d=0`, no `done` pulse.
- Busy backpressure: toggle `in_valid` with different data during SHIFT → captured `d`/dir unchanged; only the IDLE-time command is executed.

Source files
------------

// File: rtl/usr_seq.sv
// Command sequencer for univ_shift_reg: takes a word, direction and shift count over
// valid/ready and plays them out as one LOAD, the requested shifts, then a hold.
module usr_seq #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic [CW-1:0] in_shamt,
  output logic [1:0]    ctrl,
  output logic [N-1:0]  d,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  // Handshake: a command transfers on a rising edge where in_valid and in_ready are both
  // high (and reset is high); the upstream holds in_valid and its payload until then.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SHL   = 2'b01;
  localparam logic [1:0] OP_SHR   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [CW-1:0] SHAMT_MAX = CW'(N);

  state_t        state_q, state_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [N-1:0]  d_q, d_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] shamt_sat;
  logic [1:0]    shift_op;

  assign shamt_sat = (in_shamt > SHAMT_MAX) ? SHAMT_MAX : in_shamt;
  assign shift_op  = dir_q ? OP_SHR : OP_SHL;

  // Outputs are computed for the state being entered so they are registered alongside it.
  always_comb begin
    state_d = state_q;
    ctrl_d  = OP_HOLD;
    d_d     = d_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_LOAD;
          ctrl_d  = OP_LOAD;
          d_d     = in_data;
          dir_d   = in_dir;
          cnt_d   = shamt_sat;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          state_d = S_SHIFT;
          ctrl_d  = shift_op;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          ctrl_d = shift_op;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ctrl_q  <= OP_HOLD;
      d_q     <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      d_q     <= d_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign ctrl      = ctrl_q;
  assign d         = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq: N=4 instance with a behavioural shift register on its
// outputs, plus an N=5 instance for count saturation.
module tb_usr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       reset    = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data  = '0;
  logic       in_dir   = 1'b0;
  logic [2:0] in_shamt = '0;
  logic       in_ready;
  logic [1:0] ctrl;
  logic [3:0] d;
  logic       busy, done;
  logic [1:0] dbg_state;

  logic       v5      = 1'b0;
  logic [4:0] data5   = '0;
  logic       dir5    = 1'b0;
  logic [2:0] shamt5  = '0;
  logic       ready5;
  logic [1:0] ctrl5;
  logic [4:0] d5;
  logic       busy5, done5;
  logic [1:0] dbg5;

  usr_seq #(.N(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .in_shamt(in_shamt),
    .ctrl(ctrl), .d(d), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  usr_seq #(.N(5)) dut5 (
    .clk(clk), .reset(reset), .in_valid(v5), .in_ready(ready5),
    .in_data(data5), .in_dir(dir5), .in_shamt(shamt5),
    .ctrl(ctrl5), .d(d5), .busy(busy5), .done(done5), .dbg_state(dbg5)
  );

  // Downstream register model: 11 load, 01 shift left, 10 shift right, zero fill.
  logic [3:0] q_m = '0;
  always_ff @(posedge clk) begin
    case (ctrl)
      2'b11: q_m <= d;
      2'b01: q_m <= {q_m[2:0], 1'b0};
      2'b10: q_m <= {1'b0, q_m[3:1]};
      default: q_m <= q_m;
    endcase
  end

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (ctrl !== 2'b00 || d !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_state cyc%0d: ctrl=%b d=%b busy=%b done=%b rdy=%b want 00 0000 0 0 1",
                 i, ctrl, d, busy, done, in_ready);
      end
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_left();
    logic [1:0] exp_c [6] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    in_valid = 1'b1; in_data = 4'b1010; in_dir = 1'b0; in_shamt = 3'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ctrl !== exp_c[i] || done !== (i == 5) || d !== 4'b1010 || busy !== 1'b1) begin
        bad++;
        $display("FAIL left k+%0d: ctrl=%b done=%b d=%b busy=%b want %b %b 1010 1",
                 i + 1, ctrl, done, d, busy, exp_c[i], (i == 5));
      end
      if (i == 1) begin
        total++;
        if (q_m !== 4'b1010) begin
          bad++;
          $display("FAIL left_q_after_load: q=%b want 1010", q_m);
        end
      end
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || q_m !== 4'b0000) begin
      bad++;
      $display("FAIL left_end: rdy=%b busy=%b done=%b q=%b want 1 0 0 0000", in_ready, busy, done, q_m);
    end
  endtask

  task automatic test_right_partial();
    logic [1:0] exp_c [4] = '{2'b11, 2'b10, 2'b10, 2'b00};
    in_valid = 1'b1; in_data = 4'b0110; in_dir = 1'b1; in_shamt = 3'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ctrl !== exp_c[i] || busy !== 1'b1 || in_ready !== 1'b0 || done !== (i == 3)) begin
        bad++;
        $display("FAIL right k+%0d: ctrl=%b busy=%b rdy=%b done=%b want %b 1 0 %b",
                 i + 1, ctrl, busy, in_ready, done, exp_c[i], (i == 3));
      end
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || q_m !== 4'b0001) begin
      bad++;
      $display("FAIL right_end k+5: rdy=%b busy=%b q=%b want 1 0 0001", in_ready, busy, q_m);
    end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_data = 4'b1001; in_dir = 1'b0; in_shamt = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (ctrl !== 2'b11 || done !== 1'b0) begin
      bad++;
      $display("FAIL zero k+1: ctrl=%b done=%b want 11 0", ctrl, done);
    end
    @(negedge clk);
    total++;
    if (ctrl !== 2'b00 || done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL zero k+2: ctrl=%b done=%b busy=%b want 00 1 1", ctrl, done, busy);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || done !== 1'b0 || q_m !== 4'b1001) begin
      bad++;
      $display("FAIL zero k+3: rdy=%b done=%b q=%b want 1 0 1001", in_ready, done, q_m);
    end
  endtask

  task automatic test_saturate();
    int sh4, sh5;
    sh4 = 0; sh5 = 0;
    in_valid = 1'b1; in_data = 4'b0001; in_dir = 1'b0; in_shamt = 3'd7;
    v5 = 1'b1; data5 = 5'b10110; dir5 = 1'b0; shamt5 = 3'd7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      v5 = 1'b0;
      if (ctrl == 2'b01) sh4++;
      if (ctrl5 == 2'b01) sh5++;
      if (i == 0) begin
        total++;
        if (ctrl5 !== 2'b11 || d5 !== 5'b10110) begin
          bad++;
          $display("FAIL sat5_load: ctrl=%b d=%b want 11 10110", ctrl5, d5);
        end
      end
      if (i == 6) begin
        total++;
        if (ctrl5 !== 2'b00 || done5 !== 1'b1) begin
          bad++;
          $display("FAIL sat5_done k+7: ctrl=%b done=%b want 00 1", ctrl5, done5);
        end
      end
    end
    total++;
    if (sh5 !== 5) begin
      bad++;
      $display("FAIL sat5_shifts: got=%0d want 5", sh5);
    end
    total++;
    if (sh4 !== 4) begin
      bad++;
      $display("FAIL sat4_shifts: got=%0d want 4", sh4);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_c [7] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00};
    logic [3:0] exp_d [7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0101, 4'b0101, 4'b0101};
    logic       exp_n [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_r [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    in_valid = 1'b1; in_data = 4'b1010; in_dir = 1'b0; in_shamt = 3'd1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (ctrl !== exp_c[i] || d !== exp_d[i] || done !== exp_n[i] || in_ready !== exp_r[i]) begin
        bad++;
        $display("FAIL b2b k+%0d: ctrl=%b d=%b done=%b rdy=%b want %b %b %b %b",
                 i + 1, ctrl, d, done, in_ready, exp_c[i], exp_d[i], exp_n[i], exp_r[i]);
      end
      if (i == 0) begin
        in_data = 4'b0101; in_dir = 1'b1; in_shamt = 3'd1;
      end
      if (i == 4) in_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || ctrl !== 2'b00) begin
      bad++;
      $display("FAIL b2b_end: rdy=%b ctrl=%b want 1 00", in_ready, ctrl);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    in_valid = 1'b1; in_data = 4'b1100; in_dir = 1'b0; in_shamt = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ctrl !== 2'b01) begin
      bad++;
      $display("FAIL rmid_shift2: ctrl=%b want 01", ctrl);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    total++;
    if (ctrl !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1 || d !== 4'h0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rmid_after: ctrl=%b busy=%b rdy=%b d=%b done=%b want 00 0 1 0000 0",
               ctrl, busy, in_ready, d, done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL rmid_no_done: activity_cycles=%0d want 0", dones);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_c [5] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
    in_valid = 1'b1; in_data = 4'b0011; in_dir = 1'b1; in_shamt = 3'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ctrl !== exp_c[i] || d !== 4'b0011) begin
        bad++;
        $display("FAIL bp k+%0d: ctrl=%b d=%b want %b 0011", i + 1, ctrl, d, exp_c[i]);
      end
      in_data = 4'b1111; in_dir = 1'b0; in_shamt = 3'd1;
      in_valid = (i < 3) ? ~in_valid : 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ctrl !== 2'b00 || busy !== 1'b0 || d !== 4'b0011) begin
        bad++;
        $display("FAIL bp_idle%0d: ctrl=%b busy=%b d=%b want 00 0 0011", i, ctrl, busy, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_right_partial();
    test_zero();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
